// File: rtl/fetch_unit.sv
// fetch_unit: PC holder, credit-limited in-order imem requester and instruction buffer for decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc, resp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [CW:0]   credit_used;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic          fire, resp, push, pop;
  assign target         = redirect_pc & ~32'h3;
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign resp           = imem_resp_valid && outstanding != '0;
  assign push           = resp && drop_cnt == '0 && !redirect_valid;
  assign if_valid       = count != '0;
  assign pop            = if_valid && !stall && !redirect_valid;
  assign if_instr       = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc          = if_valid ? pc_mem[rd_ptr] : '0;
  // PC, credit and FIFO bookkeeping; a redirect flushes and arms discard of in-flight words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      pc          <= target;
      resp_pc     <= target;
      outstanding <= outstanding - CW'(resp);
      drop_cnt    <= outstanding - CW'(resp);
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      pc          <= fire ? pc + 32'd4 : pc;
      outstanding <= outstanding + CW'(fire) - CW'(resp);
      drop_cnt    <= (resp && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
      resp_pc     <= push ? resp_pc + 32'd4 : resp_pc;
      wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count       <= count + CW'(push) - CW'(pop);
    end
  end
  // buffer storage needs no reset: entries are only read while count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_resp_data;
    end
  end
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus randomized run against an instruction-stream reference model
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h100;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  always #5 clk = ~clk;
  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
  );
  typedef struct {
    logic        ready, resp, stall, redir;
    logic [31:0] rpc;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    int          due;
  } req_t;
  vec_t        tbl [22];
  req_t        mq [$];
  int          tests = 0, fails = 0, cyc = 0, pops = 0;
  logic [31:0] exp_pc, exp_req;
  bit          prev_hold, prev_redir, ok;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst if_valid", {31'b0, if_valid}, 32'd0);
    check("async_rst if_pc", if_pc, 32'd0);
    check("async_rst if_instr", if_instr, 32'd0);
    check("async_rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_pc = RPC;
    exp_req = RPC;
    prev_hold = 1'b0;
    prev_redir = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h110, 1'b1, 32'h108};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h110, 1'b1, 32'h10C};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h114, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h118, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h208, 1'b1, 32'h200};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 32'h200};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset if_valid", {31'b0, if_valid}, 32'd0);
    check("reset req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("reset if_pc", if_pc, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      imem_req_ready = tbl[i].ready;
      stall = tbl[i].stall;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      if (tbl[i].resp && mq.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = word(mq[0].a);
        void'(mq.pop_front());
      end
      #1;
      check($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) check($sformatf("vec%0d req_addr", i), imem_req_addr, tbl[i].exp_addr);
      check($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].exp_iv});
      if (tbl[i].exp_iv) begin
        check($sformatf("vec%0d if_pc", i), if_pc, tbl[i].exp_pc);
        check($sformatf("vec%0d if_instr", i), if_instr, word(tbl[i].exp_pc));
      end
      if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, 0});
    end
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      @(negedge clk);
      cyc++;
      imem_req_ready = ($urandom % 4) != 0;
      stall = ($urandom % 3) == 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      imem_resp_valid = 1'b0;
      imem_resp_data = '0;
      if (mq.size() > 0 && mq[0].due <= cyc && ($urandom % 4) != 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data = word(mq[0].a);
        void'(mq.pop_front());
      end
      #1;
      if (redirect_valid) check("redirect withdraws req", {31'b0, imem_req_valid}, 32'd0);
      if (imem_req_valid) check("req_addr order", imem_req_addr, exp_req);
      ok = (mq.size() + (imem_resp_valid ? 1 : 0)) <= 2;
      check("in-flight credit", {31'b0, ok}, 32'd1);
      if (prev_redir) check("flush after redirect", {31'b0, if_valid}, 32'd0);
      if (prev_hold) check("stall holds entry", {31'b0, if_valid}, 32'd1);
      if (if_valid) begin
        check("stream if_pc", if_pc, exp_pc);
        check("stream if_instr", if_instr, word(exp_pc));
      end
      prev_redir = redirect_valid;
      prev_hold = if_valid && stall && !redirect_valid;
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
        exp_req = exp_pc;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          mq.push_back('{exp_req, cyc + 1 + int'($urandom % 3)});
          exp_req = exp_req + 32'd4;
        end
        if (if_valid && !stall) begin
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
      end
    end
    check("liveness", {31'b0, pops > 200}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
